// File: rtl/prio_encoder_pipe_if.sv
// Request/grant bundle for prio_encoder_pipe: master drives requests and ready, slave returns the grant.
interface prio_encoder_pipe_if #(
    parameter int N = 8,
    parameter int W = (N < 2) ? 1 : $clog2(N)
);
    logic         enable;
    logic         mode;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;

    modport master (
        output enable, mode, req, out_ready,
        input  out_valid, out_idx, out_onehot
    );

    modport slave (
        input  enable, mode, req, out_ready,
        output out_valid, out_idx, out_onehot
    );
endinterface

// File: rtl/prio_encoder_pipe.sv
// Registered fixed/round-robin priority encoder; PRIO_ENCODER_PIPE_STICKY_EN adds pending-request capture.
// Latency: one cycle from accepted request vector to out_valid/out_idx/out_onehot.
// Backpressure: result holds while out_valid & ~out_ready; enable=0 freezes all state.
module prio_encoder_pipe #(
    parameter int N = 8,
    parameter int W = (N < 2) ? 1 : $clog2(N)
) (
    input  logic               clk,
    input  logic               clear_n,
    prio_encoder_pipe_if.slave bus
);

    logic         accept;
    logic         any;
    logic [N-1:0] eff;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] fix_sel;
    logic [W-1:0] rr_sel;
    logic [W-1:0] wrap_sel;
    logic         rr_hit;
    logic [W-1:0] sel;
    logic [N-1:0] sel_onehot;

    logic         valid_q;
    logic [W-1:0] idx_q;
    logic [N-1:0] onehot_q;

    assign accept = bus.enable & (~valid_q | bus.out_ready);
    assign any    = |eff;

`ifdef PRIO_ENCODER_PIPE_STICKY_EN
    logic [N-1:0] pending;
    logic [N-1:0] grant_onehot;

    assign eff          = pending | bus.req;
    assign grant_onehot = (accept & any) ? sel_onehot : '0;

    // Pulses seen under backpressure survive here until their own grant.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pending <= '0;
        end else if (bus.enable) begin
            pending <= eff & ~grant_onehot;
        end
    end
`else
    assign eff = bus.req;
`endif

    always_comb begin
        fix_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (eff[i]) fix_sel = W'(i);
        end
    end

    // Descending scan so the last hit is the lowest index; wrap_sel covers the no-hit-above-ptr case.
    always_comb begin
        rr_sel   = '0;
        wrap_sel = '0;
        rr_hit   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eff[i]) begin
                wrap_sel = W'(i);
                if (i >= int'(ptr)) begin
                    rr_sel = W'(i);
                    rr_hit = 1'b1;
                end
            end
        end
        if (!rr_hit) rr_sel = wrap_sel;
    end

    assign sel        = bus.mode ? rr_sel : fix_sel;
    assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel;
    assign ptr_next   = (sel == W'(N - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr      <= '0;
        end else if (accept) begin
            valid_q  <= any;
            onehot_q <= any ? sel_onehot : '0;
            if (any) idx_q <= sel;
            if (any && bus.mode) ptr <= ptr_next;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Randomized + directed bench for prio_encoder_pipe with a queue scoreboard and behavioural model.
module tb_prio_encoder_pipe;
    localparam int N = 8;
    localparam int W = $clog2(N);

    logic clk = 1'b0;
    logic clear_n;
    always #5 clk = ~clk;

    prio_encoder_pipe_if #(.N(N), .W(W)) bus ();
    prio_encoder_pipe #(.N(N), .W(W)) dut (.clk(clk), .clear_n(clear_n), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: current output state, pointer, pending set, and grants awaiting consumption.
    bit m_valid;
    int m_idx;
    int m_ptr;
    bit m_pend[N];
    int q[$];

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic chk_out(input string name, input longint v, input longint idx, input longint oh);
        chk({name, "_valid"},  longint'(bus.out_valid),  v);
        chk({name, "_idx"},    longint'(bus.out_idx),    idx);
        chk({name, "_onehot"}, longint'(bus.out_onehot), oh);
    endtask

    function automatic int pick(input bit eff[N], input bit rr, input int ptr);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) if (eff[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (eff[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        q.delete();
    endtask

    // Checks current DUT state against the model, then drives new inputs and predicts the next edge.
    task automatic apply(input bit en, input bit md, input logic [N-1:0] rq, input bit rdy);
        bit acc;
        bit eff[N];
        int g;
        chk("state_valid",  longint'(bus.out_valid),  longint'(m_valid));
        chk("state_idx",    longint'(bus.out_idx),    longint'(m_idx));
        chk("state_onehot", longint'(bus.out_onehot), m_valid ? (64'd1 << m_idx) : 64'd0);
        bus.enable    = en;
        bus.mode      = md;
        bus.req       = rq;
        bus.out_ready = rdy;
        acc = en && (!m_valid || rdy);
        for (int i = 0; i < N; i++) begin
`ifdef PRIO_ENCODER_PIPE_STICKY_EN
            eff[i] = rq[i] || m_pend[i];
`else
            eff[i] = rq[i];
`endif
        end
        g = acc ? pick(eff, md, m_ptr) : -1;
        if (acc) begin
            if (g < 0) begin
                m_valid = 0;
            end else begin
                m_valid = 1;
                m_idx   = g;
                q.push_back(g);
                if (md) m_ptr = (g + 1) % N;
            end
        end
`ifdef PRIO_ENCODER_PIPE_STICKY_EN
        if (en) for (int i = 0; i < N; i++) m_pend[i] = eff[i] && (i != g);
`endif
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 0);
        model_reset();
        apply(1'b0, bus.mode, '0, 1'b1);
        #1;
        clear_n = 1'b1;
    endtask

    // Monitor: every handshake consumes the oldest predicted grant.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (clear_n && bus.enable && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL xfer: got unexpected grant idx %0d, expected none", bus.out_idx);
                end else begin
                    e = q.pop_front();
                    chk("xfer_idx",    longint'(bus.out_idx),    longint'(e));
                    chk("xfer_onehot", longint'(bus.out_onehot), 64'd1 << e);
                end
            end
        end
    end

    initial begin
        model_reset();
        bus.enable    = 1'b0;
        bus.mode      = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b0;
        clear_n       = 1'b1;
        #1 clear_n = 1'b0;
        #2 chk_out("reset", 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) clear_n = 1'b1;
        settle();

        apply(1, 0, 8'b0010_1100, 1); settle(); chk_out("fixed", 1, 5, 8'h20);

        do_reset(); settle();
        apply(1, 0, 8'h20, 1); settle(); chk_out("bp_setup", 1, 5, 8'h20);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 8'h01, 0); settle(); chk_out("bp_hold", 1, 5, 8'h20);
        end
        apply(1, 0, 8'h01, 1); settle(); chk_out("bp_release", 1, 0, 8'h01);
        apply(1, 0, 8'h00, 1); settle(); chk_out("idle", 0, 0, 0);

        for (int k = 0; k < 9; k++) begin
            apply(1, 1, 8'hFF, 1); settle(); chk_out("rr_seq", 1, k % 8, 64'd1 << (k % 8));
        end

        do_reset(); settle();
        apply(1, 1, 8'h03, 1); settle(); chk_out("rr_after_reset", 1, 0, 8'h01);
        apply(1, 1, 8'h02, 1); settle(); chk_out("rr_ptr_setup", 1, 1, 8'h02);
        apply(1, 1, 8'h82, 1); settle(); chk_out("rr_wrap_hi", 1, 7, 8'h80);
        apply(1, 1, 8'h82, 1); settle(); chk_out("rr_wrap_lo", 1, 1, 8'h02);

        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 8'hFF, 1); settle(); chk_out("freeze", 1, 1, 8'h02);
        end
        apply(1, 1, 8'h06, 1); settle(); chk_out("freeze_ptr", 1, 2, 8'h04);

        do_reset(); settle();
        apply(1, 0, 8'h81, 1); settle(); chk_out("pulse_first", 1, 7, 8'h80);
        apply(1, 0, 8'h00, 1); settle();
`ifdef PRIO_ENCODER_PIPE_STICKY_EN
        chk_out("pulse_second", 1, 0, 8'h01);
        apply(1, 0, 8'h00, 1); settle(); chk_out("pulse_done", 0, 0, 0);
`else
        chk_out("pulse_second", 0, 7, 0);
        apply(1, 0, 8'h00, 1); settle(); chk_out("pulse_done", 0, 7, 0);
`endif

        for (int k = 0; k < 2000; k++) begin
            logic [N-1:0] r;
            r = N'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) r = '0;
            apply($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0 ? ~bus.mode : bus.mode,
                  r, $urandom_range(0, 3) != 0);
            settle();
        end

        for (int k = 0; k < N + 2; k++) begin
            apply(1, 0, 8'h00, 1); settle();
        end
        chk("drain_empty", longint'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prio_encoder_pipe.md
PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 Parameter N, default 8: number of request inputs, legal range 2..64.
REQ-002 Parameter W, default $clog2(N) (minimum 1): width of the encoded index.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clear_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  when 1, the block may sample requests; when 0, all state holds.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-007 req  input  N  request vector; bit i set means input i is requesting.
REQ-008 out_ready  input  1  downstream accepts the current result.
REQ-009 out_valid  output  1  out_idx and out_onehot hold a valid grant.
REQ-010 out_idx  output  W  encoded index of the granted request.
REQ-011 out_onehot  output  N  one-hot form of the grant, equal to 1 << out_idx when out_valid=1, otherwise 0.

Function
REQ-012 accept = enable & (~out_valid | out_ready); all sampling, grant and pointer updates occur only on cycles where accept=1.
REQ-013 eff = req without sticky mode, or (pending | req) with sticky mode (REQ-024).
REQ-014 On accept with eff != 0, the next cycle shall have out_valid=1, out_idx = selected index, and out_onehot = the matching one-hot value; latency is exactly 1 cycle.
REQ-015 On accept with eff == 0, the next cycle shall have out_valid=0, out_onehot=0, and out_idx holding its previous value.
REQ-016 While out_valid=1 and out_ready=0: out_valid, out_idx and out_onehot shall hold stable, and req shall be ignored apart from sticky accumulation.
REQ-017 Fixed mode: the highest-numbered set bit of eff wins.
REQ-018 Round-robin mode: the lowest set bit at index >= ptr wins, wrapping to index 0 when no such bit exists; ptr is a log2(N)-bit internal pointer.
REQ-019 On every accepted grant in round-robin mode, ptr <= (granted index + 1) mod N; ptr shall not change in fixed mode or on cycles with no grant.
REQ-020 A mode change takes effect at the next accept; ptr is not cleared by a mode change.
REQ-021 enable=0 freezes everything: outputs, ptr and pending all hold, including when out_ready=1.
REQ-022 Bits of req at index >= N do not exist; for non-power-of-two N, ptr wraps at N, not at 2^W.

Reset
REQ-023 While clear_n=0, asynchronously: out_valid=0, out_idx=0, out_onehot=0, ptr=0, pending=0; normal operation resumes on the first rising clk edge after clear_n rises, and any grant in flight is discarded.

Configuration
REQ-024 Macro PRIO_ENCODER_PIPE_STICKY_EN, when defined, adds an N-bit pending register. Every cycle with enable=1, pending <= (pending | req) & ~(accepted grant one-hot), so a single-cycle request pulse is held until it is granted, even under backpressure.
REQ-025 When PRIO_ENCODER_PIPE_STICKY_EN is undefined, no pending register exists, eff = req, and requests not present on an accept cycle are lost.

Verification
REQ-026 Reset: assert clear_n=0 mid-grant with out_valid=1 -> out_valid=0, out_idx=0, out_onehot=0 immediately without a clock edge; after release, an RR grant starts from index 0.
REQ-027 Fixed priority, N=8: mode=0, req=8'b0010_1100, enable=1, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_onehot=8'b0010_0000.
REQ-028 Backpressure: with out_idx=5 valid, set out_ready=0 and req=8'h01 for 3 cycles -> outputs hold idx 5; then set out_ready=1 -> idx 5 consumed and the next cycle shows idx 0.
REQ-029 Round-robin, N=8: mode=1, req=8'hFF held, out_ready=1 -> out_idx sequence 0,1,2,3,4,5,6,7,0; with req=8'b1000_0010 and ptr=2 -> grant 7, then 1.
REQ-030 Idle and freeze: req=0 -> out_valid=0 one cycle later; enable=0 with req=8'hFF -> outputs and ptr unchanged for 4 cycles.
REQ-031 Sticky check: one-cycle pulse req=8'h81, mode=0, out_ready=1 -> with macro, idx 7 then idx 0 then out_valid=0; without macro, idx 7 then out_valid=0.
